// File: rtl/fft_axi_pkg.sv
// Shared types for the FFT sample-memory AXI4 slaves.
package fft_axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_t;

  // AXI4 WRAP bursts may only be 2, 4, 8 or 16 beats long.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/fft_axi_wr_slave_if.sv
// AXI4 write-channel bundle (AW, W, B) between a master and the sample-memory slave.
interface fft_axi_wr_slave_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int ID_W   = 2
);
  import fft_axi_pkg::*;

  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic [ID_W-1:0]   AWID;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  resp_t             BRESP;
  logic              BVALID;
  logic              BREADY;

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

endinterface

// File: rtl/fft_axi_addr_gen.sv
// Next-word-address generator for AXI bursts; shared with the read-channel slave.
module fft_axi_addr_gen
  import fft_axi_pkg::*;
#(
  parameter int MADDR_W = 11
) (
  input  logic [MADDR_W-1:0] addr_i,
  input  burst_t             burst_i,
  input  logic [7:0]         len_i,
  output logic [MADDR_W-1:0] addr_o
);

  logic [MADDR_W-1:0] addr_inc;
  logic [MADDR_W-1:0] wrap_mask;

  // Legal wrap lengths are 2^n-1, so AWLEN itself is the in-window offset mask.
  assign addr_inc  = addr_i + MADDR_W'(1);
  assign wrap_mask = MADDR_W'(len_i);

  // Select the next address by burst type; FIXED and reserved hold the address.
  always_comb begin
    addr_o = addr_i;
    case (burst_i)
      INCR:    addr_o = addr_inc;
      WRAP:    addr_o = (addr_i & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/fft_axi_wr_slave.sv
// AXI4 write slave that loads time-domain samples into the FFT sample memory
// and flags a completed frame to start the FFT core.
//
//   state | meaning
//   IDLE  | AWREADY high, waiting for a burst address
//   DATA  | WREADY high, accepting beats until the beat counter reaches AWLEN
//   RESP  | BVALID high, holding BID/BRESP until BREADY
module fft_axi_wr_slave
  import fft_axi_pkg::*;
#(
  parameter  int DATA_W  = 16,
  parameter  int ADDR_W  = 12,
  parameter  int ID_W    = 2,
  parameter  int SAMP_W  = 12,
  localparam int STRB_W  = DATA_W / 8,
  localparam int LSB     = $clog2(STRB_W),
  localparam int MADDR_W = ADDR_W - LSB
) (
  input  logic                clk,
  input  logic                Reset,
  fft_axi_wr_slave_if.slave   axi,
  input  logic [SAMP_W-1:0]   SAMP_NUMBER,
  output logic                MEM_WE,
  output logic [MADDR_W-1:0]  MEM_ADDR,
  output logic [DATA_W-1:0]   MEM_WDATA,
  output logic [STRB_W-1:0]   MEM_BE,
  output logic                FRAME_DONE
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << LSB) - 1);

  wr_state_t          state_q, state_d;
  logic [MADDR_W-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_q, beat_d;
  burst_t             burst_q, burst_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [MADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  be_q, be_d;
  logic [SAMP_W-1:0]  fcnt_q, fcnt_d;
  logic [SAMP_W-1:0]  samp_q, samp_d;
  logic               fdone_q, fdone_d;

  logic               aw_hs, w_hs, last_beat, wlast_bad, aw_err, wr_en;
  logic [SAMP_W-1:0]  samp_eff, fcnt_inc;

  // Ready/valid come from the registered state; AWREADY is also held off during reset.
  assign axi.AWREADY = (state_q == IDLE) && !Reset;
  assign axi.WREADY  = (state_q == DATA);
  assign axi.BVALID  = (state_q == RESP);
  assign axi.BID     = id_q;
  assign axi.BRESP   = ((state_q == RESP) && err_q) ? SLVERR : OKAY;

  assign MEM_WE     = we_q;
  assign MEM_ADDR   = maddr_q;
  assign MEM_WDATA  = wdata_q;
  assign MEM_BE     = be_q;
  assign FRAME_DONE = fdone_q;

  assign aw_hs     = axi.AWVALID && axi.AWREADY;
  assign w_hs      = axi.WVALID && (state_q == DATA);
  assign last_beat = (beat_q == len_q);
  assign wlast_bad = (axi.WLAST != last_beat);

  // Only AXI-legal bursts are written: full-width beats, no reserved type,
  // and WRAP with a legal length and a beat-aligned start.
  assign aw_err = (axi.AWSIZE != 3'(LSB))
               || (axi.AWBURST == RSVD)
               || ((axi.AWBURST == WRAP)
                   && (!wrap_len_ok(axi.AWLEN) || ((axi.AWADDR & ALIGN_MASK) != '0)));

  // Once an error is seen (including on this beat) the rest of the burst is dropped.
  assign wr_en = w_hs && !err_q && !wlast_bad && (|axi.WSTRB);

  // Frame length is taken from SAMP_NUMBER only at the start of a frame.
  assign samp_eff = (fcnt_q == '0) ? SAMP_NUMBER : samp_q;
  assign fcnt_inc = fcnt_q + SAMP_W'(1);

  fft_axi_addr_gen #(.MADDR_W(MADDR_W)) u_addr_gen (
    .addr_i  (addr_q),
    .burst_i (burst_q),
    .len_i   (len_q),
    .addr_o  (addr_nxt)
  );

  // Next-state, burst bookkeeping, memory write and frame counting.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    burst_d = burst_q;
    id_d    = id_q;
    err_d   = err_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    fcnt_d  = fcnt_q;
    samp_d  = samp_q;
    fdone_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (aw_hs) begin
          state_d = DATA;
          addr_d  = axi.AWADDR[ADDR_W-1:LSB];
          len_d   = axi.AWLEN;
          burst_d = burst_t'(axi.AWBURST);
          id_d    = axi.AWID;
          err_d   = aw_err;
          beat_d  = 8'd0;
        end
      end
      DATA: begin
        if (w_hs) begin
          beat_d = beat_q + 8'd1;
          addr_d = addr_nxt;
          err_d  = err_q || wlast_bad;
          if (last_beat) state_d = RESP;
        end
      end
      RESP: begin
        if (axi.BREADY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      we_d    = 1'b1;
      maddr_d = addr_q;
      wdata_d = axi.WDATA;
      be_d    = axi.WSTRB;
      if (samp_eff != '0) begin
        samp_d = samp_eff;
        if (fcnt_inc == samp_eff) begin
          fdone_d = 1'b1;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_inc;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Burst context, memory port and frame counter registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      burst_q <= FIXED;
      id_q    <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      fcnt_q  <= '0;
      samp_q  <= '0;
      fdone_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      burst_q <= burst_d;
      id_q    <= id_d;
      err_q   <= err_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      fcnt_q  <= fcnt_d;
      samp_q  <= samp_d;
      fdone_q <= fdone_d;
    end
  end

endmodule

// File: tb/tb_fft_axi_wr_slave.sv
// Bench for fft_axi_wr_slave: directed bursts followed by random bursts, all
// checked against a burst-level model of addresses, errors and frame pulses.
module tb_fft_axi_wr_slave;
  import fft_axi_pkg::*;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 12;
  localparam int ID_W    = 2;
  localparam int SAMP_W  = 12;
  localparam int STRB_W  = 2;
  localparam int MADDR_W = 11;

  logic                clk = 1'b0;
  logic                Reset;
  logic [SAMP_W-1:0]   SAMP_NUMBER;
  logic                MEM_WE;
  logic [MADDR_W-1:0]  MEM_ADDR;
  logic [DATA_W-1:0]   MEM_WDATA;
  logic [STRB_W-1:0]   MEM_BE;
  logic                FRAME_DONE;

  fft_axi_wr_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) axi_if ();

  fft_axi_wr_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .SAMP_W(SAMP_W)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .axi         (axi_if),
    .SAMP_NUMBER (SAMP_NUMBER),
    .MEM_WE      (MEM_WE),
    .MEM_ADDR    (MEM_ADDR),
    .MEM_WDATA   (MEM_WDATA),
    .MEM_BE      (MEM_BE),
    .FRAME_DONE  (FRAME_DONE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int be;
    int fd;
  } wr_t;

  wr_t  act_q[$];
  wr_t  exp_q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   stray_fd = 0;
  int   f_cnt    = 0;
  int   f_lat    = 0;

  logic [15:0] bdata [256];
  logic [1:0]  bstrb [256];
  logic        bwlast[256];

  // Capture every memory write; a FRAME_DONE without a write is an error.
  always @(negedge clk) begin
    if (MEM_WE === 1'b1) begin
      wr_t e;
      e.addr = int'(MEM_ADDR);
      e.data = int'(MEM_WDATA);
      e.be   = int'(MEM_BE);
      e.fd   = int'(FRAME_DONE);
      act_q.push_back(e);
    end else if (FRAME_DONE !== 1'b0) begin
      stray_fd++;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: time limit reached, observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Word address of beat i, from the AXI burst rules.
  function automatic int exp_addr(input int a0, input int len, input int burst, input int i);
    int n, base;
    if (burst == 1) return (a0 + i) % 2048;
    if (burst == 2) begin
      n    = len + 1;
      base = (a0 / n) * n;
      return base + ((a0 - base + i) % n);
    end
    return a0;
  endfunction

  // One counted sample; returns 1 when it completes a frame.
  function automatic int frame_step(input int samp);
    if (f_cnt == 0) f_lat = samp;
    if (f_lat == 0) return 0;
    f_cnt++;
    if (f_cnt == f_lat) begin
      f_cnt = 0;
      return 1;
    end
    return 0;
  endfunction

  task automatic fill_beats(input int len);
    for (int i = 0; i <= len; i++) begin
      bdata[i]  = 16'($urandom);
      bstrb[i]  = 2'b11;
      bwlast[i] = (i == len);
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_nwr"}, 64'(act_q.size()), 64'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, 64'(act_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_data"}, 64'(act_q[i].data), 64'(exp_q[i].data));
      check({tag, "_be"},   64'(act_q[i].be),   64'(exp_q[i].be));
      check({tag, "_fd"},   64'(act_q[i].fd),   64'(exp_q[i].fd));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 64'(axi_if.AWREADY), 64'(0));
    check({tag, "_wready"},  64'(axi_if.WREADY),  64'(0));
    check({tag, "_bvalid"},  64'(axi_if.BVALID),  64'(0));
    check({tag, "_bresp"},   64'(axi_if.BRESP),   64'(0));
    check({tag, "_bid"},     64'(axi_if.BID),     64'(0));
    check({tag, "_mem_we"},  64'(MEM_WE),         64'(0));
    check({tag, "_mem_addr"},64'(MEM_ADDR),       64'(0));
    check({tag, "_mem_wd"},  64'(MEM_WDATA),      64'(0));
    check({tag, "_mem_be"},  64'(MEM_BE),         64'(0));
    check({tag, "_fdone"},   64'(FRAME_DONE),     64'(0));
  endtask

  // Full burst: model, drive AW/W/B from negedges, check response timing and writes.
  task automatic do_burst(input int addr, input int len, input int size, input int burst,
                          input int id, input int bdelay, input int samp, input string tag);
    int  a0, t;
    bit  err;
    wr_t e;
    logic [1:0] exp_resp;

    a0  = (addr % 4096) / 2;
    err = (size != 1) || (burst == 3)
       || ((burst == 2) && !(len inside {1, 3, 7, 15}))
       || ((burst == 2) && (addr % 2 != 0));
    for (int i = 0; i <= len; i++) begin
      if (bwlast[i] != (i == len)) err = 1'b1;
      if (!err && (bstrb[i] != 2'b00)) begin
        e.addr = exp_addr(a0, len, burst, i);
        e.data = int'(bdata[i]);
        e.be   = int'(bstrb[i]);
        e.fd   = frame_step(samp);
        exp_q.push_back(e);
      end
    end
    exp_resp = err ? 2'b10 : 2'b00;

    SAMP_NUMBER     = SAMP_W'(samp);
    axi_if.AWADDR   = ADDR_W'(addr);
    axi_if.AWLEN    = 8'(len);
    axi_if.AWSIZE   = 3'(size);
    axi_if.AWBURST  = 2'(burst);
    axi_if.AWID     = ID_W'(id);
    axi_if.AWVALID  = 1'b1;
    t = 0;
    while (axi_if.AWREADY !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_awready"}, 64'(axi_if.AWREADY), 64'(1));
    @(negedge clk);
    axi_if.AWVALID = 1'b0;
    check({tag, "_wready_lat"}, 64'(axi_if.WREADY), 64'(1));

    for (int i = 0; i <= len; i++) begin
      axi_if.WDATA  = bdata[i];
      axi_if.WSTRB  = bstrb[i];
      axi_if.WLAST  = bwlast[i];
      axi_if.WVALID = 1'b1;
      t = 0;
      while (axi_if.WREADY !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
    end
    axi_if.WVALID = 1'b0;
    axi_if.WLAST  = 1'b0;

    check({tag, "_bvalid_lat"}, 64'(axi_if.BVALID), 64'(1));
    check({tag, "_bresp"},      64'(axi_if.BRESP),  64'(exp_resp));
    check({tag, "_bid"},        64'(axi_if.BID),    64'(id));
    for (int d = 0; d < bdelay; d++) begin
      @(negedge clk);
      check({tag, "_bvalid_hold"}, 64'(axi_if.BVALID),  64'(1));
      check({tag, "_bresp_hold"},  64'(axi_if.BRESP),   64'(exp_resp));
      check({tag, "_bid_hold"},    64'(axi_if.BID),     64'(id));
      check({tag, "_awready_lo"},  64'(axi_if.AWREADY), 64'(0));
    end
    axi_if.BREADY = 1'b1;
    @(negedge clk);
    axi_if.BREADY = 1'b0;
    check({tag, "_awready_after_b"}, 64'(axi_if.AWREADY), 64'(1));
    check({tag, "_bvalid_drop"},     64'(axi_if.BVALID),  64'(0));
    compare_writes(tag);
  endtask

  initial begin
    int burst, len, addr, size, samp, bdelay, t;

    Reset          = 1'b1;
    SAMP_NUMBER    = '0;
    axi_if.AWADDR  = '0;
    axi_if.AWLEN   = '0;
    axi_if.AWSIZE  = '0;
    axi_if.AWBURST = '0;
    axi_if.AWID    = '0;
    axi_if.AWVALID = 1'b0;
    axi_if.WDATA   = '0;
    axi_if.WSTRB   = '0;
    axi_if.WLAST   = 1'b0;
    axi_if.WVALID  = 1'b0;
    axi_if.BREADY  = 1'b0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    Reset = 1'b0;
    @(negedge clk);
    check("awready_after_reset", 64'(axi_if.AWREADY), 64'(1));

    fill_beats(3);
    bdata[0] = 16'h1111; bdata[1] = 16'h2222; bdata[2] = 16'h3333; bdata[3] = 16'h4444;
    do_burst('h010, 3, 1, 1, 2, 0, 0, "incr4");

    fill_beats(3);
    do_burst('h00C, 3, 1, 2, 1, 1, 0, "wrap4");

    fill_beats(2);
    do_burst('h00C, 2, 1, 2, 3, 0, 0, "wrap_badlen");

    fill_beats(3);
    do_burst('h100, 3, 1, 1, 0, 0, 8, "frame_a");
    fill_beats(3);
    do_burst('h108, 3, 1, 1, 1, 0, 8, "frame_b");
    fill_beats(3);
    do_burst('h110, 3, 1, 1, 2, 0, 8, "frame_c");

    fill_beats(3);
    do_burst('h200, 3, 0, 1, 1, 0, 8, "badsize");

    fill_beats(3);
    bwlast[1] = 1'b1;
    do_burst('h220, 3, 1, 1, 3, 0, 8, "early_wlast");

    fill_beats(3);
    do_burst('h300, 3, 1, 0, 2, 5, 8, "bready_hold");

    samp = 5;
    for (int k = 0; k < 40; k++) begin
      burst = $urandom_range(0, 9);
      burst = (burst < 3) ? 0 : (burst < 6) ? 1 : (burst < 9) ? 2 : 3;
      len   = $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      addr  = $urandom_range(0, 4095);
      if (burst == 2 && $urandom_range(0, 7) != 0) addr = addr & ~1;
      size  = ($urandom_range(0, 9) == 0) ? 0 : 1;
      if ($urandom_range(0, 3) == 0) samp = $urandom_range(0, 3) * 3;
      bdelay = $urandom_range(0, 3);
      for (int i = 0; i <= len; i++) begin
        bdata[i]  = 16'($urandom);
        bstrb[i]  = 2'($urandom_range(0, 3));
        bwlast[i] = (i == len);
      end
      if ($urandom_range(0, 7) == 0) begin
        t = $urandom_range(0, len);
        bwlast[t] = ~bwlast[t];
      end
      do_burst(addr, len, size, burst, $urandom_range(0, 3), bdelay, samp, "rand");
    end

    // Reset during beat 2 of an 8-beat burst: beats 0 and 1 land, no response follows.
    SAMP_NUMBER = 12'd4;
    fill_beats(7);
    for (int i = 0; i < 2; i++) begin
      wr_t e;
      e.addr = 'h100 + i;
      e.data = int'(bdata[i]);
      e.be   = 3;
      e.fd   = frame_step(4);
      exp_q.push_back(e);
    end
    axi_if.AWADDR  = 12'h200;
    axi_if.AWLEN   = 8'd7;
    axi_if.AWSIZE  = 3'd1;
    axi_if.AWBURST = 2'b01;
    axi_if.AWID    = 2'd3;
    axi_if.AWVALID = 1'b1;
    t = 0;
    while (axi_if.AWREADY !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid_awready", 64'(axi_if.AWREADY), 64'(1));
    @(negedge clk);
    axi_if.AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      axi_if.WDATA  = bdata[i];
      axi_if.WSTRB  = bstrb[i];
      axi_if.WLAST  = 1'b0;
      axi_if.WVALID = 1'b1;
      if (i == 2) Reset = 1'b1;
      @(negedge clk);
    end
    check_all_zero("rst_mid");
    Reset = 1'b0;
    axi_if.WVALID = 1'b0;
    f_cnt = 0;
    f_lat = 0;
    for (int d = 0; d < 4; d++) begin
      @(negedge clk);
      check("rst_mid_no_b", 64'(axi_if.BVALID), 64'(0));
    end
    compare_writes("rst_mid");

    fill_beats(3);
    do_burst('h040, 3, 1, 1, 1, 0, 4, "after_rst");

    check("stray_frame_done", 64'(stray_fd), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
